// File: rtl/enc_buf_collect.sv
// Encoder snapshot collector: scans enabled channel/type selects on each tick
// and packs a header plus sample words into a host-readable FIFO.
module enc_buf_collect #(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 256,
    parameter int AW           = 8
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    cfg_en,
    input  logic [NUM_CHANNELS-1:0] cfg_chan_mask,
    input  logic [4:0]              cfg_type_mask,
    input  logic                    sample_tick,
    output logic [3:0]              buf_data_chan,
    output logic [3:0]              buf_data_type,
    input  logic [31:0]             buf_collect_data,
    input  logic                    rd_en,
    output logic [31:0]             rd_data,
    output logic [AW:0]             fifo_count,
    output logic                    fifo_empty,
    output logic                    busy,
    output logic [7:0]              drop_cnt,
    output logic                    overrun,
    input  logic                    clr_status
);

    localparam logic [3:0] OFF_BUF_ENC_DATA = 4'd0;
    localparam logic [3:0] OFF_BUF_ENC_PER  = 4'd1;
    localparam logic [3:0] OFF_BUF_ENC_QTR1 = 4'd2;
    localparam logic [3:0] OFF_BUF_ENC_QTR5 = 4'd3;
    localparam logic [3:0] OFF_BUF_ENC_RUN  = 4'd4;
    localparam int         NT               = 5;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, HDR, SCAN, FLUSH} state_t;

    state_t state, state_d;

    logic [NUM_CHANNELS-1:0] chan_m;
    logic [4:0]  type_m;
    logic [7:0]  k_q, rem_q, pos_q;
    logic [3:0]  seq;
    logic [15:0] ts, ts_q;
    logic [7:0]  k_new;
    int          nc, ntp, lb;
    logic        tick_ok, has_room, accept, drop;
    logic        nxt_found;
    logic [7:0]  nxt_idx;
    logic [3:0]  nxt_c, nxt_t;
    logic        wr_en, adv, do_rd;
    logic [31:0] wr_data;
    logic [AW-1:0] wp, rp;
    logic [31:0] mem [DEPTH];

    function automatic logic [3:0] type_code(input int t);
        case (t)
            0:       return OFF_BUF_ENC_DATA;
            1:       return OFF_BUF_ENC_PER;
            2:       return OFF_BUF_ENC_QTR1;
            3:       return OFF_BUF_ENC_QTR5;
            default: return OFF_BUF_ENC_RUN;
        endcase
    endfunction

    always_comb begin
        nc  = 0;
        ntp = 0;
        for (int c = 0; c < NUM_CHANNELS; c++) nc += int'(cfg_chan_mask[c]);
        for (int t = 0; t < NT; t++) ntp += int'(cfg_type_mask[t]);
        k_new = 8'(nc * ntp);
    end

    assign tick_ok  = sample_tick && cfg_en && |cfg_chan_mask && |cfg_type_mask;
    assign has_room = (DEPTH - int'(fifo_count)) >= (int'(k_new) + 1);
    assign accept   = (state == IDLE) && tick_ok && has_room;
    assign drop     = (state == IDLE) && tick_ok && !has_room;

    // Flattened index c*5+t orders the scan channel-major, type-minor.
    always_comb begin
        lb        = (state == HDR) ? 0 : int'(pos_q) + 1;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        nxt_c     = '0;
        nxt_t     = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int t = 0; t < NT; t++) begin
                if (!nxt_found && chan_m[c] && type_m[t] && (c * NT + t) >= lb) begin
                    nxt_found = 1'b1;
                    nxt_idx   = 8'(c * NT + t);
                    nxt_c     = 4'(c + 1);
                    nxt_t     = type_code(t);
                end
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        wr_en   = 1'b0;
        wr_data = buf_collect_data;
        adv     = 1'b0;
        unique case (state)
            IDLE: if (accept) state_d = HDR;
            HDR: begin
                wr_en   = 1'b1;
                wr_data = {4'hE, seq, k_q, ts_q};
                adv     = 1'b1;
                state_d = (k_q == 8'd1) ? FLUSH : SCAN;
            end
            SCAN: begin
                wr_en = 1'b1;
                adv   = 1'b1;
                if (rem_q == 8'd1) state_d = FLUSH;
            end
            FLUSH: begin
                wr_en   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            chan_m        <= '0;
            type_m        <= '0;
            k_q           <= '0;
            rem_q         <= '0;
            pos_q         <= '0;
            seq           <= '0;
            ts            <= '0;
            ts_q          <= '0;
            buf_data_chan <= '0;
            buf_data_type <= '0;
            drop_cnt      <= '0;
            overrun       <= 1'b0;
        end else begin
            ts <= ts + 16'd1;
            if (accept) begin
                chan_m <= cfg_chan_mask;
                type_m <= cfg_type_mask;
                k_q    <= k_new;
                ts_q   <= ts;
            end
            if (adv) begin
                buf_data_chan <= nxt_c;
                buf_data_type <= nxt_t;
                pos_q         <= nxt_idx;
                rem_q         <= (state == HDR) ? k_q - 8'd1 : rem_q - 8'd1;
            end
            if (state == FLUSH) seq <= seq + 4'd1;
            if (clr_status) begin
                drop_cnt <= '0;
                overrun  <= 1'b0;
            end else begin
                if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                if (sample_tick && state != IDLE) overrun <= 1'b1;
            end
        end
    end

    assign do_rd      = rd_en && !fifo_empty;
    assign fifo_empty = (fifo_count == '0);
    assign busy       = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (wr_en) mem[wp] <= wr_data;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            fifo_count <= '0;
            rd_data    <= '0;
        end else begin
            if (wr_en) wp <= wp + PTR_ONE;
            if (do_rd) begin
                rp      <= rp + PTR_ONE;
                rd_data <= mem[rp];
            end
            if (wr_en && !do_rd)      fifo_count <= fifo_count + CNT_ONE;
            else if (!wr_en && do_rd) fifo_count <= fifo_count - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_enc_buf_collect.sv
// Bench for enc_buf_collect: queue-based frame/FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_enc_buf_collect;

    localparam int NCH   = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic           sysclk = 1'b0;
    logic           reset;
    logic           cfg_en;
    logic [NCH-1:0] cfg_chan_mask;
    logic [4:0]     cfg_type_mask;
    logic           sample_tick;
    logic [3:0]     buf_data_chan, buf_data_type;
    logic [31:0]    buf_collect_data;
    logic           rd_en;
    logic [31:0]    rd_data;
    logic [AW:0]    fifo_count;
    logic           fifo_empty, busy, overrun, clr_status;
    logic [7:0]     drop_cnt;

    logic [31:0] mux_tab [16][16];
    assign buf_collect_data = mux_tab[buf_data_chan][buf_data_type];

    enc_buf_collect #(.NUM_CHANNELS(NCH), .DEPTH(DEPTH), .AW(AW)) dut (
        .sysclk(sysclk), .reset(reset), .cfg_en(cfg_en),
        .cfg_chan_mask(cfg_chan_mask), .cfg_type_mask(cfg_type_mask),
        .sample_tick(sample_tick), .buf_data_chan(buf_data_chan),
        .buf_data_type(buf_data_type), .buf_collect_data(buf_collect_data),
        .rd_en(rd_en), .rd_data(rd_data), .fifo_count(fifo_count),
        .fifo_empty(fifo_empty), .busy(busy), .drop_cnt(drop_cnt),
        .overrun(overrun), .clr_status(clr_status)
    );

    always #5 sysclk = ~sysclk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is a list of words emitted one per cycle after acceptance.
    logic [31:0] m_fifo [$];
    logic [31:0] m_frame [$];
    logic [7:0]  m_sel [$];
    logic [15:0] m_ts;
    logic [3:0]  m_seq, m_chan, m_type;
    logic [7:0]  m_drop;
    logic        m_ovr;
    logic [31:0] m_rd;

    always @(posedge sysclk) begin
        int  cnt_pre, k;
        bit  busy_pre, drop_ev, ovr_ev;
        if (reset) begin
            m_fifo.delete(); m_frame.delete(); m_sel.delete();
            m_ts = 0; m_seq = 0; m_chan = 0; m_type = 0;
            m_drop = 0; m_ovr = 0; m_rd = 0;
        end else begin
            cnt_pre  = m_fifo.size();
            busy_pre = (m_frame.size() != 0);
            drop_ev  = 0;
            ovr_ev   = sample_tick && busy_pre;
            if (rd_en && cnt_pre > 0) m_rd = m_fifo.pop_front();
            if (busy_pre) begin
                m_fifo.push_back(m_frame.pop_front());
                if (m_sel.size() != 0) {m_chan, m_type} = m_sel.pop_front();
                if (m_frame.size() == 0) m_seq = m_seq + 4'd1;
            end
            if (!busy_pre && sample_tick && cfg_en && |cfg_chan_mask && |cfg_type_mask) begin
                k = 0;
                for (int c = 1; c <= NCH; c++)
                    for (int t = 0; t < 5; t++)
                        if (cfg_chan_mask[c-1] && cfg_type_mask[t]) k++;
                if (DEPTH - cnt_pre >= k + 1) begin
                    m_frame.push_back({4'hE, m_seq, 8'(k), m_ts});
                    for (int c = 1; c <= NCH; c++)
                        for (int t = 0; t < 5; t++)
                            if (cfg_chan_mask[c-1] && cfg_type_mask[t]) begin
                                m_frame.push_back(mux_tab[c][t]);
                                m_sel.push_back({4'(c), 4'(t)});
                            end
                end else drop_ev = 1;
            end
            if (clr_status) begin
                m_drop = 0;
                m_ovr  = 0;
            end else begin
                if (drop_ev && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                if (ovr_ev) m_ovr = 1;
            end
            m_ts = m_ts + 16'd1;
        end
    end

    always @(negedge sysclk) begin
        if (chk_on) begin
            chk("busy", 32'(busy), 32'(m_frame.size() != 0));
            chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
            chk("fifo_empty", 32'(fifo_empty), 32'(m_fifo.size() == 0));
            chk("rd_data", rd_data, m_rd);
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("sel_chan", 32'(buf_data_chan), 32'(m_chan));
            chk("sel_type", 32'(buf_data_type), 32'(m_type));
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic tick(input logic [3:0] cm, input logic [4:0] tm);
        cfg_chan_mask = cm;
        cfg_type_mask = tm;
        sample_tick   = 1;
        step();
        sample_tick   = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic read_word(output logic [31:0] w);
        rd_en = 1;
        step();
        rd_en = 0;
        w = rd_data;
    endtask

    task automatic drain();
        int n = 0;
        while (!fifo_empty && n < 100) begin
            rd_en = 1;
            step();
            n++;
        end
        rd_en = 0;
        chk("drain_empty", 32'(fifo_empty), 32'd1);
    endtask

    task automatic check_full_frame(input string nm);
        logic [31:0] w;
        read_word(w);
        chk({nm, "_k"}, 32'(w[23:16]), 32'd20);
        for (int c = 1; c <= NCH; c++)
            for (int t = 0; t < 5; t++) begin
                read_word(w);
                chk({nm, "_word"}, w, {4'(c), 4'(t), 24'h0});
            end
    endtask

    initial begin
        logic [31:0] w;
        int rd_pct;
        for (int c = 0; c < 16; c++)
            for (int t = 0; t < 16; t++) mux_tab[c][t] = 32'h0;
        reset = 1; cfg_en = 1; cfg_chan_mask = 0; cfg_type_mask = 0;
        sample_tick = 0; rd_en = 0; clr_status = 0;
        step();
        chk_on = 1;
        repeat (2) step();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_sel", {buf_data_chan, buf_data_type}, 32'd0);
        reset = 0;
        repeat (16) step();

        mux_tab[1][0] = 32'h0100_0123;
        tick(4'b0001, 5'b00001);
        chk("sf_busy0", 32'(busy), 32'd1);
        step();
        chk("sf_busy1", 32'(busy), 32'd1);
        step();
        chk("sf_busy2", 32'(busy), 32'd0);
        chk("sf_count", 32'(fifo_count), 32'd2);
        read_word(w);
        chk("sf_hdr", w, 32'hE001_0010);
        read_word(w);
        chk("sf_data", w, 32'h0100_0123);

        for (int c = 1; c <= NCH; c++)
            for (int t = 0; t < 5; t++) mux_tab[c][t] = {4'(c), 4'(t), 24'h0};
        tick(4'hF, 5'h1F);
        wait_idle();
        chk("fs_count", 32'(fifo_count), 32'd21);
        read_word(w);
        chk("fs_hdr", 32'(w[31:16]), 32'hE114);
        for (int c = 1; c <= NCH; c++)
            for (int t = 0; t < 5; t++) begin
                read_word(w);
                chk("fs_word", w, {4'(c), 4'(t), 24'h0});
            end

        tick(4'hF, 5'h1F); wait_idle();
        tick(4'b0011, 5'b00011); wait_idle();
        tick(4'b0001, 5'b00011); wait_idle();
        chk("sp_fill", 32'(fifo_count), 32'(DEPTH - 3));
        tick(4'b0011, 5'b00011);
        chk("sp_drop_busy", 32'(busy), 32'd0);
        chk("sp_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("sp_drop_count", 32'(fifo_count), 32'(DEPTH - 3));
        rd_en = 1; step(); step(); rd_en = 0;
        tick(4'b0011, 5'b00011);
        chk("sp_accept", 32'(busy), 32'd1);
        wait_idle();
        chk("sp_full", 32'(fifo_count), 32'(DEPTH));
        drain();

        tick(4'hF, 5'h1F);
        repeat (3) step();
        sample_tick = 1; cfg_en = 0;
        cfg_chan_mask = 4'b0001; cfg_type_mask = 5'b00001;
        step();
        sample_tick = 0; cfg_en = 1;
        wait_idle();
        chk("ov_flag", 32'(overrun), 32'd1);
        chk("ov_count", 32'(fifo_count), 32'd21);
        check_full_frame("ov");
        clr_status = 1; step(); clr_status = 0;
        chk("clr_ovr", 32'(overrun), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);

        rd_en = 1; step(); rd_en = 0;
        chk("empty_rd", rd_data, 32'h4400_0000);
        tick(4'b0001, 5'b00001); wait_idle();
        tick(4'b0001, 5'b00001);
        rd_en = 1; step(); rd_en = 0;
        chk("cc_count", 32'(fifo_count), 32'd2);
        wait_idle();
        chk("cc_count2", 32'(fifo_count), 32'd3);
        drain();

        tick(4'hF, 5'h1F);
        repeat (4) step();
        reset = 1; step();
        chk("mr_count", 32'(fifo_count), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_sel", {buf_data_chan, buf_data_type}, 32'd0);
        chk("mr_rd", rd_data, 32'd0);
        reset = 0;
        tick(4'b0001, 5'b00001);
        wait_idle();
        read_word(w);
        chk("mr_hdr", w, 32'hE001_0000);
        drain();

        for (int c = 1; c <= NCH; c++)
            for (int t = 0; t < 5; t++) mux_tab[c][t] = $urandom;
        rd_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) rd_pct = $urandom_range(5, 90);
            cfg_en        = ($urandom_range(0, 7) != 0);
            cfg_chan_mask = 4'($urandom);
            cfg_type_mask = 5'($urandom);
            sample_tick   = ($urandom_range(0, 5) == 0);
            rd_en         = ($urandom_range(0, 99) < rd_pct);
            clr_status    = ($urandom_range(0, 49) == 0);
            reset         = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 0; sample_tick = 0; clr_status = 0; rd_en = 0;
        wait_idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
